// File: rtl/serial_tx_arb_pkg.sv
// Shared types and constants for the serial transmit arbiter and its round-robin picker.
package serial_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter
  import serial_tx_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan from the farthest offset down so the closest requester to ptr is applied last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    hit_s       = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      cand_s      = IW'((int'(ptr) + off) % N);
      hit_s       = req[cand_s];
      grant_valid = grant_valid | hit_s;
      grant_idx   = hit_s ? cand_s : grant_idx;
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter; streams each granted word MSB-first.
// Optional macro SERIAL_TX_ARB_TAG_EN prefixes every word with tag byte 8'hA0 | grant index.
module serial_tx_arbiter
  import serial_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [7:0]                        tx_data,
  output logic                              tx_new_data,
  input  logic                              tx_busy,
  output logic                              active,
  output logic [idx_width(NUM_REQ)-1:0]     grant_idx
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int DW = WORD_BYTES * 8;
`ifdef SERIAL_TX_ARB_TAG_EN
  localparam int FRAME_BYTES = WORD_BYTES + 1;
`else
  localparam int FRAME_BYTES = WORD_BYTES;
`endif
  localparam int SW = FRAME_BYTES * 8;
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BYTES - 1);

  state_t               state_r, state_nx_s;
  logic [SW-1:0]        shift_r, shift_nx_s;
  logic [CW-1:0]        cnt_r, cnt_nx_s;
  logic [IW-1:0]        ptr_r, ptr_nx_s;
  logic [IW-1:0]        grant_idx_r, grant_idx_nx_s;
  logic [NUM_REQ-1:0]   req_ack_r, req_ack_nx_s;
  logic [7:0]           tx_data_r, tx_data_nx_s;
  logic                 tx_new_data_r, tx_new_data_nx_s;
  logic                 active_r, active_nx_s;

  logic                 arb_valid_s;
  logic [IW-1:0]        arb_idx_s;
  logic [DW-1:0]        word_s;
  logic [SW-1:0]        frame_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req         (req_valid),
    .ptr         (ptr_r),
    .grant_valid (arb_valid_s),
    .grant_idx   (arb_idx_s)
  );

  assign word_s = req_data[int'(arb_idx_s)*DW +: DW];

`ifdef SERIAL_TX_ARB_TAG_EN
  logic [7:0] idx8_s;
  assign idx8_s  = 8'(arb_idx_s);
  assign frame_s = {TAG_BASE | {4'h0, idx8_s[3:0]}, word_s};
`else
  assign frame_s = word_s;
`endif

  // Next-state and next-output logic of the grant/send/handshake sequencer.
  always_comb begin
    state_nx_s       = state_r;
    shift_nx_s       = shift_r;
    cnt_nx_s         = cnt_r;
    ptr_nx_s         = ptr_r;
    grant_idx_nx_s   = grant_idx_r;
    req_ack_nx_s     = {NUM_REQ{1'b0}};
    tx_data_nx_s     = tx_data_r;
    tx_new_data_nx_s = 1'b0;
    active_nx_s      = active_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          shift_nx_s     = frame_s;
          req_ack_nx_s   = NUM_REQ'(1) << arb_idx_s;
          grant_idx_nx_s = arb_idx_s;
          active_nx_s    = 1'b1;
          cnt_nx_s       = LAST_CNT;
          state_nx_s     = SEND;
        end else begin
          active_nx_s    = 1'b0;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_nx_s     = shift_r[SW-1 -: 8];
          tx_new_data_nx_s = 1'b1;
          state_nx_s       = WAIT_HI;
        end else begin
          state_nx_s       = SEND;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nx_s = WAIT_LO;
        end else begin
          state_nx_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (cnt_r == {CW{1'b0}}) begin
            state_nx_s  = IDLE;
            active_nx_s = 1'b0;
            ptr_nx_s    = (grant_idx_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : grant_idx_r + IW'(1);
          end else begin
            shift_nx_s  = shift_r << 4'd8;
            cnt_nx_s    = cnt_r - CW'(1);
            state_nx_s  = SEND;
          end
        end else begin
          state_nx_s = WAIT_LO;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      shift_r       <= {SW{1'b0}};
      cnt_r         <= {CW{1'b0}};
      ptr_r         <= {IW{1'b0}};
      grant_idx_r   <= {IW{1'b0}};
      req_ack_r     <= {NUM_REQ{1'b0}};
      tx_data_r     <= 8'h00;
      tx_new_data_r <= 1'b0;
      active_r      <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      shift_r       <= shift_nx_s;
      cnt_r         <= cnt_nx_s;
      ptr_r         <= ptr_nx_s;
      grant_idx_r   <= grant_idx_nx_s;
      req_ack_r     <= req_ack_nx_s;
      tx_data_r     <= tx_data_nx_s;
      tx_new_data_r <= tx_new_data_nx_s;
      active_r      <= active_nx_s;
    end
  end

  assign req_ack     = req_ack_r;
  assign tx_data     = tx_data_r;
  assign tx_new_data = tx_new_data_r;
  assign active      = active_r;
  assign grant_idx   = grant_idx_r;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a behavioural UART transmitter (CLK_PER_BIT=4).
module tb_serial_tx_arbiter;

  localparam int NR        = 4;
  localparam int WB        = 4;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;
`ifdef SERIAL_TX_ARB_TAG_EN
  localparam int FB = WB + 1;
`else
  localparam int FB = WB;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req_valid = 4'b0000;
  logic [127:0]  req_data = 128'h0;
  logic [3:0]    req_ack;
  logic [7:0]    tx_data;
  logic          tx_new_data;
  logic          tx_busy;
  logic          active;
  logic [1:0]    grant_idx;

  logic          busy_m = 1'b0;
  logic          force_busy = 1'b0;
  int            bcnt = 0;
  int            n_pulses = 0;
  int            n_acks = 0;
  int            n_collide = 0;
  logic [7:0]    sent[$];

  int            n_checks = 0;
  int            n_fail = 0;

  assign tx_busy = busy_m | force_busy;

  serial_tx_arbiter #(
    .NUM_REQ    (NR),
    .WORD_BYTES (WB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .tx_busy     (tx_busy),
    .active      (active),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  // Behavioural transmitter (no reset) plus pulse/ack/collision accounting.
  always @(posedge clk) begin
    if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy_m <= 1'b0;
    end
    if (tx_new_data) begin
      n_pulses <= n_pulses + 1;
      if (tx_busy) begin
        n_collide <= n_collide + 1;
      end else begin
        sent.push_back(tx_data);
        busy_m <= 1'b1;
        bcnt   <= FRAME_CYC;
      end
    end
    if (req_ack != 4'b0000) n_acks <= n_acks + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int i, input int v);
    return {8'(16 * i + v), 8'h5A, 8'(i + 1), 8'hC3};
  endfunction

  task automatic check_frame(input string tag, input int base, input logic [31:0] w, input int idx);
    logic [7:0] e[$];
    logic [7:0] obs;
`ifdef SERIAL_TX_ARB_TAG_EN
    e.push_back(8'hA0 | 8'(idx));
`endif
    for (int k = 0; k < WB; k++) e.push_back(w[31-8*k -: 8]);
    chk({tag, "_len"}, 32'(sent.size() >= base + FB), 32'd1);
    for (int k = 0; k < FB; k++) begin
      obs = (base + k < sent.size()) ? sent[base+k] : 8'hxx;
      chk({tag, "_byte"}, 32'(obs), 32'(e[k]));
    end
  endtask

  task automatic wait_ack(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle_timeout"}, 32'(ok), 32'd1);
  endtask

  int p0, p1, a1;
  int ver[4];
  int e;
  bit reached;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_new", 32'(tx_new_data), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_gidx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;

    // Single word from requester 2, latency and ordering
    @(negedge clk);
    sent.delete();
    p0 = n_pulses;
    req_data[64 +: 32] = 32'hDEADBEEF;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ack", 32'(req_ack), 32'h4);
    chk("single_gidx", 32'(grant_idx), 32'd2);
    chk("single_active", 32'(active), 32'd1);
    chk("single_new_early", 32'(tx_new_data), 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_new", 32'(tx_new_data), 32'd1);
`ifdef SERIAL_TX_ARB_TAG_EN
    chk("single_first", 32'(tx_data), 32'hA2);
`else
    chk("single_first", 32'(tx_data), 32'hDE);
`endif
    chk("single_ack_pulse", 32'(req_ack), 32'd0);
    @(negedge clk);
    chk("single_new_pulse", 32'(tx_new_data), 32'd0);
    wait_idle("single");
    chk("single_busy_at_idle", 32'(tx_busy), 32'd0);
    chk("single_pulses", 32'(n_pulses - p0), 32'(FB));
    chk("single_hold", 32'(tx_data), 32'hEF);
    check_frame("single", 0, 32'hDEADBEEF, 2);

    // Wrap and fairness: ptr=3, requests 3 and 0, then 0 alone again
    @(negedge clk);
    sent.delete();
    req_data[0 +: 32]  = mkw(0, 0);
    req_data[96 +: 32] = mkw(3, 0);
    req_valid = 4'b1001;
    wait_ack("wrap1");
    chk("wrap1_ack", 32'(req_ack), 32'h8);
    chk("wrap1_gidx", 32'(grant_idx), 32'd3);
    req_valid = 4'b0001;
    wait_ack("wrap2");
    chk("wrap2_ack", 32'(req_ack), 32'h1);
    chk("wrap2_gidx", 32'(grant_idx), 32'd0);
    req_data[0 +: 32] = mkw(0, 1);
    wait_ack("wrap3");
    chk("wrap3_ack", 32'(req_ack), 32'h1);
    chk("wrap3_gidx", 32'(grant_idx), 32'd0);
    req_valid = 4'b0000;
    wait_idle("wrap");
    check_frame("wrap_f0", 0, mkw(3, 0), 3);
    check_frame("wrap_f1", FB, mkw(0, 0), 0);
    check_frame("wrap_f2", 2 * FB, mkw(0, 1), 0);

    // Busy gating: transmitter held busy for ~20 cycles
    @(negedge clk);
    force_busy = 1'b1;
    sent.delete();
    p0 = n_pulses;
    req_data[32 +: 32] = 32'hCAFEF00D;
    req_valid = 4'b0010;
    wait_ack("busy");
    chk("busy_ack", 32'(req_ack), 32'h2);
    req_valid = 4'b0000;
    repeat (19) @(negedge clk);
    chk("busy_no_pulse", 32'(n_pulses - p0), 32'd0);
    chk("busy_new_low", 32'(tx_new_data), 32'd0);
    force_busy = 1'b0;
    wait_idle("busy");
    chk("busy_pulses", 32'(n_pulses - p0), 32'(FB));
    check_frame("busy", 0, 32'hCAFEF00D, 1);

    // Reset after the second byte of requester 3's word
    @(negedge clk);
    sent.delete();
    p0 = n_pulses;
    req_data[96 +: 32] = 32'h11223344;
    req_valid = 4'b1000;
    wait_ack("mid");
    chk("mid_ack", 32'(req_ack), 32'h8);
    req_valid = 4'b0000;
    reached = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (n_pulses - p0 >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("mid_two_bytes", 32'(reached), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    chk("mid_rst_new", 32'(tx_new_data), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'd0);
    chk("mid_rst_gidx", 32'(grant_idx), 32'd0);
    p1 = n_pulses;
    a1 = n_acks;
    repeat (150) @(negedge clk);
    chk("mid_no_pulse", 32'(n_pulses - p1), 32'd0);
    chk("mid_no_ack", 32'(n_acks - a1), 32'd0);
    sent.delete();
    req_data[32 +: 32] = mkw(1, 2);
    req_data[96 +: 32] = mkw(3, 2);
    req_valid = 4'b1010;
    wait_ack("fresh");
    chk("fresh_ack", 32'(req_ack), 32'h2);
    chk("fresh_gidx", 32'(grant_idx), 32'd1);
    req_valid = 4'b0000;
    wait_idle("fresh");
    check_frame("fresh", 0, mkw(1, 2), 1);

    // Contention: all four valid, refreshed after each ack
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sent.delete();
    for (int i = 0; i < 4; i++) begin
      ver[i] = 0;
      req_data[i*32 +: 32] = mkw(i, 0);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("cont");
      e = k % 4;
      chk("cont_ack", 32'(req_ack), 32'(4'(1) << e));
      chk("cont_gidx", 32'(grant_idx), 32'(e));
      ver[e] = ver[e] + 1;
      req_data[e*32 +: 32] = mkw(e, ver[e]);
      if (k == 4) req_valid = 4'b0000;
    end
    wait_idle("cont");
    for (int k = 0; k < 4; k++) check_frame("cont_f", k * FB, mkw(k, 0), k);
    check_frame("cont_f4", 4 * FB, mkw(0, 1), 0);
    chk("no_collision", 32'(n_collide), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
